// File: rtl/tick_gen_pkg.sv
// Shared constants and helpers for the multi-channel tick generator.
package tick_gen_pkg;

   // Board-level default: one tick per second from a 300 MHz clock.
   localparam int unsigned TICK_DEFAULT_PERIOD = 300_000_000;

   function automatic int CH_IDX_W(input int ch);
      return (ch > 1) ? $clog2(ch) : 1;
   endfunction

endpackage

// File: rtl/tick_generator_if.sv
// Control/status bundle between the tick generator and its consumer.
interface tick_generator_if import tick_gen_pkg::*; #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 32
);
   logic [CHANNELS-1:0]            enable;
   logic [CHANNELS-1:0]            oneshot;
   logic                           load;
   logic [CH_IDX_W(CHANNELS)-1:0]  load_ch;
   logic [WIDTH-1:0]               load_period;
   logic [CHANNELS-1:0]            tick;
   logic [CHANNELS-1:0]            busy;

   modport master (output enable, oneshot, load, load_ch, load_period,
                   input  tick, busy);
   modport slave  (input  enable, oneshot, load, load_ch, load_period,
                   output tick, busy);
endinterface

// File: rtl/tick_channel.sv
// One programmable tick channel: period register, counter and one-shot arm flag.
module tick_channel #(
   parameter int               WIDTH          = 32,
   parameter logic [WIDTH-1:0] DEFAULT_PERIOD = WIDTH'(tick_gen_pkg::TICK_DEFAULT_PERIOD)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             oneshot,
   input  logic             load_hit,
   input  logic [WIDTH-1:0] load_period,
   output logic             tick,
   output logic             busy
);
   logic [WIDTH-1:0] per;
   logic [WIDTH-1:0] cnt;
   logic             armed;

   // Priority: reset, then load, then enable-low re-arm, then counting.
   always_ff @(posedge clk) begin
      if (!reset) begin
         per   <= DEFAULT_PERIOD;
         cnt   <= '0;
         armed <= 1'b1;
         tick  <= 1'b0;
      end else if (load_hit) begin
         per   <= load_period;
         cnt   <= '0;
         armed <= 1'b1;
         tick  <= 1'b0;
      end else if (!enable) begin
         cnt   <= '0;
         armed <= 1'b1;
         tick  <= 1'b0;
      end else if (!armed || per == '0) begin
         cnt   <= '0;
         tick  <= 1'b0;
      end else if (cnt == per - WIDTH'(1)) begin
         cnt   <= '0;
         tick  <= 1'b1;
         if (oneshot) armed <= 1'b0;
      end else begin
         cnt   <= cnt + WIDTH'(1);
         tick  <= 1'b0;
      end
   end

   assign busy = enable && armed && (per != '0);

endmodule

// File: rtl/tick_generator.sv
// CHANNELS independent clock-enable tick sources with a shared period-load port.
module tick_generator import tick_gen_pkg::*; #(
   parameter int               CHANNELS       = 4,
   parameter int               WIDTH          = 32,
   parameter logic [WIDTH-1:0] DEFAULT_PERIOD = WIDTH'(TICK_DEFAULT_PERIOD)
) (
   input  logic       clk,
   input  logic       reset,
   tick_generator_if.slave bus
);
   logic [CHANNELS-1:0] load_hit;

   // Out-of-range channel indices match no instance and are dropped.
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      assign load_hit[i] = bus.load && (int'(bus.load_ch) == i);

      tick_channel #(
         .WIDTH          (WIDTH),
         .DEFAULT_PERIOD (DEFAULT_PERIOD)
      ) u_ch (
         .clk         (clk),
         .reset       (reset),
         .enable      (bus.enable[i]),
         .oneshot     (bus.oneshot[i]),
         .load_hit    (load_hit[i]),
         .load_period (bus.load_period),
         .tick        (bus.tick[i]),
         .busy        (bus.busy[i])
      );
   end

endmodule

// File: tb/tb_tick_generator.sv
// Directed bench: periodic table, then one-shot, terminal-count load and reset corners.
module tb_tick_generator;
   import tick_gen_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   tick_generator_if #(.CHANNELS(4), .WIDTH(8)) bus ();
   tick_generator_if #(.CHANNELS(3), .WIDTH(8)) bus3 ();

   tick_generator #(.CHANNELS(4), .WIDTH(8), .DEFAULT_PERIOD(8'd5)) dut (
      .clk(clk), .reset(reset), .bus(bus));
   tick_generator #(.CHANNELS(3), .WIDTH(8), .DEFAULT_PERIOD(8'd5)) dut3 (
      .clk(clk), .reset(reset), .bus(bus3));

   typedef struct {
      logic [3:0] en;
      logic       ld;
      logic [1:0] ch;
      logic [7:0] p;
      logic [3:0] xt;
      logic [3:0] xb;
      logic [2:0] xt3;
   } vec_t;

   vec_t tbl [16];
   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, got, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.enable = 4'hF;  bus.oneshot = '0;  bus.load = 1'b0;
      bus.load_ch = '0;   bus.load_period = '0;
      bus3.enable = 3'h7; bus3.oneshot = '0; bus3.load = 1'b0;
      bus3.load_ch = 2'd3; bus3.load_period = '0;

      for (int k = 0; k < 16; k++) begin
         tbl[k] = '{en: 4'hF, ld: 1'b0, ch: 2'd0, p: 8'd0,
                    xt: (k % 5 == 4) ? 4'hF : 4'h0, xb: 4'hF,
                    xt3: (k % 5 == 4) ? 3'h7 : 3'h0};
         if (k >= 11) begin
            tbl[k].xt = (k == 14) ? 4'b0111 : 4'b0100;
            tbl[k].xb = 4'b0111;
         end
      end
      tbl[10].ld = 1'b1; tbl[10].ch = 2'd2; tbl[10].p = 8'd1; tbl[10].xt = 4'h0;
      tbl[11].ld = 1'b1; tbl[11].ch = 2'd3; tbl[11].p = 8'd0;

      repeat (3) cyc;
      chk("reset_tick", 32'(bus.tick), 32'h0);
      chk("reset_busy", 32'(bus.busy), 32'hF);
      chk("reset_tick3", 32'(bus3.tick), 32'h0);
      reset = 1'b1;

      for (int k = 0; k < 16; k++) begin
         bus.enable = tbl[k].en; bus.load = tbl[k].ld;
         bus.load_ch = tbl[k].ch; bus.load_period = tbl[k].p;
         bus3.load = (k == 2);
         cyc;
         chk($sformatf("tbl%0d_tick", k), 32'(bus.tick), 32'(tbl[k].xt));
         chk($sformatf("tbl%0d_busy", k), 32'(bus.busy), 32'(tbl[k].xb));
         chk($sformatf("tbl%0d_tick3", k), 32'(bus3.tick), 32'(tbl[k].xt3));
         chk($sformatf("tbl%0d_busy3", k), 32'(bus3.busy), 32'h7);
      end
      bus.load = 1'b0; bus3.load = 1'b0;

      // One-shot on ch1, period 3, then re-arm by dropping enable for a cycle.
      bus.oneshot = 4'b0010;
      bus.load = 1'b1; bus.load_ch = 2'd1; bus.load_period = 8'd3;
      cyc;
      bus.load = 1'b0;
      chk("os_load_tick", 32'(bus.tick[1]), 32'd0);
      chk("os_load_busy", 32'(bus.busy[1]), 32'd1);
      for (int i = 1; i <= 6; i++) begin
         cyc;
         chk($sformatf("os%0d_tick", i), 32'(bus.tick[1]), 32'(i == 3));
         chk($sformatf("os%0d_busy", i), 32'(bus.busy[1]), 32'(i < 3));
         chk($sformatf("os%0d_ch2", i), 32'(bus.tick[2]), 32'd1);
      end
      bus.enable[1] = 1'b0;
      cyc;
      chk("os_drop_tick", 32'(bus.tick[1]), 32'd0);
      chk("os_drop_busy", 32'(bus.busy[1]), 32'd0);
      bus.enable[1] = 1'b1;
      #1;
      chk("os_rearm_busy", 32'(bus.busy[1]), 32'd1);
      for (int i = 0; i < 6; i++) begin
         cyc;
         chk($sformatf("os_re%0d_tick", i), 32'(bus.tick[1]), 32'(i == 2));
         chk($sformatf("os_re%0d_busy", i), 32'(bus.busy[1]), 32'(i < 2));
      end

      // Load ch0 exactly on its terminal-count edge: that tick is lost.
      bus.oneshot = '0;
      bus.load = 1'b1; bus.load_ch = 2'd0; bus.load_period = 8'd4;
      cyc;
      bus.load = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         bus.load = (i == 8);
         cyc;
         bus.load = 1'b0;
         chk($sformatf("tc%0d_tick0", i), 32'(bus.tick[0]), 32'(i == 4 || i == 12));
      end

      // Reset with a simultaneous load: reset wins, all channels back to period 5.
      bus.enable = 4'hF;
      bus.load = 1'b1; bus.load_ch = 2'd2; bus.load_period = 8'd9;
      reset = 1'b0;
      cyc;
      reset = 1'b1; bus.load = 1'b0;
      chk("rst_mid_tick", 32'(bus.tick), 32'h0);
      chk("rst_mid_busy", 32'(bus.busy), 32'hF);
      for (int i = 0; i < 10; i++) begin
         cyc;
         chk($sformatf("rst_re%0d_tick", i), 32'(bus.tick), (i % 5 == 4) ? 32'hF : 32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
